// File: rtl/mul_bist_pkg.sv
// Shared types and constants for the fp_mul self-test controller.
package mul_bist_pkg;

    // Controller states: one pattern walks FETCH -> APPLY -> CHECK.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_APPLY = 3'd2,
        ST_CHECK = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    // Bit positions of the fields inside one golden-pattern word.
    localparam int IN1_MSB  = 48;
    localparam int IN1_LSB  = 33;
    localparam int IN2_MSB  = 32;
    localparam int IN2_LSB  = 17;
    localparam int EXP_MSB  = 16;
    localparam int EXP_LSB  = 1;
    localparam int MODE_BIT = 0;

    // Width of the mismatch counter.
    localparam int ERR_CNT_W = 8;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at its all-ones value; clear has priority over increment.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: clear, saturating increment, or hold.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/mul_bist_ctrl.sv
// Self-test initiator for fp_mul: walks the golden-pattern memory, drives the
// multiplier operands and compares its product against the expected field.
module mul_bist_ctrl
    import mul_bist_pkg::*;
#(
    parameter int PATTERN_NUM = 10,
    parameter int ADDR_W      = 4,
    parameter int DATA_W      = 16,
    parameter int PAT_W       = 49
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    output logic [ADDR_W-1:0]    pat_addr,
    input  logic [PAT_W-1:0]     pat_rdata,
    output logic                 mul_mode,
    output logic [DATA_W-1:0]    mul_in1,
    output logic [DATA_W-1:0]    mul_in2,
    input  logic [DATA_W-1:0]    mul_result,
    input  logic                 mul_error,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [ERR_CNT_W-1:0] error_cnt,
    output logic                 fail_valid,
    output logic [ADDR_W-1:0]    fail_idx,
    output logic                 dut_err_seen
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(PATTERN_NUM - 1);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   pat_addr_q, pat_addr_d;
    logic [DATA_W-1:0]   mul_in1_q, mul_in1_d;
    logic [DATA_W-1:0]   mul_in2_q, mul_in2_d;
    logic                mul_mode_q, mul_mode_d;
    logic [DATA_W-1:0]   exp_q, exp_d;
    logic                fail_valid_q, fail_valid_d;
    logic [ADDR_W-1:0]   fail_idx_q, fail_idx_d;
    logic                dut_err_seen_q, dut_err_seen_d;
    logic                cnt_clr;
    logic                cnt_inc;
    logic                mismatch;

    // Only the product is compared; the multiplier's error flag is merely recorded.
    assign mismatch = (mul_result != exp_q);

    // Next-state and datapath decisions for the pattern walk.
    always_comb begin
        state_d        = state_q;
        pat_addr_d     = pat_addr_q;
        mul_in1_d      = mul_in1_q;
        mul_in2_d      = mul_in2_q;
        mul_mode_d     = mul_mode_q;
        exp_d          = exp_q;
        fail_valid_d   = fail_valid_q;
        fail_idx_d     = fail_idx_q;
        dut_err_seen_d = dut_err_seen_q;
        cnt_clr        = 1'b0;
        cnt_inc        = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                // A run from DONE behaves exactly like one from IDLE.
                if (start) begin
                    cnt_clr        = 1'b1;
                    fail_valid_d   = 1'b0;
                    fail_idx_d     = '0;
                    dut_err_seen_d = 1'b0;
                    pat_addr_d     = '0;
                    state_d        = ST_FETCH;
                end
            end
            ST_FETCH: begin
                // Memory is sampling pat_addr; its word is valid in APPLY.
                state_d = ST_APPLY;
            end
            ST_APPLY: begin
                mul_in1_d  = pat_rdata[IN1_MSB:IN1_LSB];
                mul_in2_d  = pat_rdata[IN2_MSB:IN2_LSB];
                exp_d      = pat_rdata[EXP_MSB:EXP_LSB];
                mul_mode_d = pat_rdata[MODE_BIT];
                state_d    = ST_CHECK;
            end
            ST_CHECK: begin
                // Operands have been stable for this whole cycle.
                if (mismatch) begin
                    cnt_inc = 1'b1;
                    if (!fail_valid_q) begin
                        fail_valid_d = 1'b1;
                        fail_idx_d   = pat_addr_q;
                    end
                end
                if (mul_error) begin
                    dut_err_seen_d = 1'b1;
                end
                if (pat_addr_q == LAST_IDX) begin
                    state_d = ST_DONE;
                end else begin
                    pat_addr_d = pat_addr_q + ADDR_W'(1);
                    state_d    = ST_FETCH;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            pat_addr_q     <= '0;
            mul_in1_q      <= '0;
            mul_in2_q      <= '0;
            mul_mode_q     <= 1'b0;
            exp_q          <= '0;
            fail_valid_q   <= 1'b0;
            fail_idx_q     <= '0;
            dut_err_seen_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            pat_addr_q     <= pat_addr_d;
            mul_in1_q      <= mul_in1_d;
            mul_in2_q      <= mul_in2_d;
            mul_mode_q     <= mul_mode_d;
            exp_q          <= exp_d;
            fail_valid_q   <= fail_valid_d;
            fail_idx_q     <= fail_idx_d;
            dut_err_seen_q <= dut_err_seen_d;
        end
    end

    sat_counter #(
        .W (ERR_CNT_W)
    ) u_err_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr),
        .inc   (cnt_inc),
        .cnt   (error_cnt)
    );

    assign pat_addr     = pat_addr_q;
    assign mul_in1      = mul_in1_q;
    assign mul_in2      = mul_in2_q;
    assign mul_mode     = mul_mode_q;
    assign fail_valid   = fail_valid_q;
    assign fail_idx     = fail_idx_q;
    assign dut_err_seen = dut_err_seen_q;

    // Status flags are pure decodes of the registered state.
    assign busy = (state_q == ST_FETCH) || (state_q == ST_APPLY) || (state_q == ST_CHECK);
    assign done = (state_q == ST_DONE);
    assign pass = done && (error_cnt == '0);

endmodule

// File: tb/tb_mul_bist_ctrl.sv
// Bench for mul_bist_ctrl: pattern memories, a behavioural fp_mul model and
// a scoreboard of expected operands and run results.
module tb_mul_bist_ctrl;

    localparam int N  = 10;
    localparam int NS = 300;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // Main instance
    logic        start = 1'b0;
    logic [3:0]  pat_addr;
    logic [48:0] pat_rdata;
    logic        mul_mode;
    logic [15:0] mul_in1, mul_in2, mul_result;
    logic        mul_error;
    logic        busy, done, pass, fail_valid, dut_err_seen;
    logic [7:0]  error_cnt;
    logic [3:0]  fail_idx;

    // Saturation instance
    logic        start_s = 1'b0;
    logic [8:0]  pat_addr_s;
    logic [48:0] pat_rdata_s;
    logic        mul_mode_s;
    logic [15:0] mul_in1_s, mul_in2_s, mul_result_s;
    logic        busy_s, done_s, pass_s, fail_valid_s, dut_err_seen_s;
    logic [7:0]  error_cnt_s;
    logic [8:0]  fail_idx_s;

    logic [48:0] mem   [0:N-1];
    logic [48:0] mem_s [0:NS-1];
    logic        err_force = 1'b0;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [15:0] in1;
        logic [15:0] in2;
        logic        mode;
    } op_t;

    typedef struct packed {
        logic [7:0] cnt;
        logic       fvalid;
        logic [3:0] fidx;
        logic       pass;
        logic       derr;
    } res_t;

    op_t  op_q[$];
    res_t res_q[$];

    logic [15:0] in1_t [0:N-1] = '{16'h3C00, 16'h4200, 16'h0003, 16'hC000, 16'h1234,
                                   16'h4500, 16'h0000, 16'h00FF, 16'h3555, 16'hFFFF};
    logic [15:0] in2_t [0:N-1] = '{16'h4000, 16'h4400, 16'h0005, 16'h3800, 16'h0010,
                                   16'h4500, 16'h4000, 16'h0101, 16'h4000, 16'h0002};
    logic        mode_t[0:N-1] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    logic        corrupt[0:N-1];

    // Behavioural fp_mul: mode 1 is a truncating fp16 multiply for normal
    // operands, mode 0 is a 16-bit integer multiply.
    function automatic logic [15:0] fp_model(input logic [15:0] a, input logic [15:0] b,
                                             input logic mode);
        logic [31:0] ip;
        logic [21:0] p;
        logic [9:0]  m;
        int          e;
        if (!mode) begin
            ip = a * b;
            return ip[15:0];
        end
        if (a[14:10] == 5'd0 || b[14:10] == 5'd0)
            return {a[15] ^ b[15], 15'd0};
        p = {1'b1, a[9:0]} * {1'b1, b[9:0]};
        e = int'(a[14:10]) + int'(b[14:10]) - 15;
        if (p[21]) begin
            m = p[20:11];
            e = e + 1;
        end else begin
            m = p[19:10];
        end
        return {a[15] ^ b[15], e[4:0], m};
    endfunction

    assign mul_result   = fp_model(mul_in1, mul_in2, mul_mode);
    assign mul_error    = err_force && (pat_addr == 4'd2);
    assign mul_result_s = fp_model(mul_in1_s, mul_in2_s, mul_mode_s);

    // Registered-read pattern memories.
    always @(posedge clk) begin
        pat_rdata   <= mem[pat_addr];
        pat_rdata_s <= mem_s[pat_addr_s];
    end

    mul_bist_ctrl #(.PATTERN_NUM(N), .ADDR_W(4), .DATA_W(16), .PAT_W(49)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .pat_addr(pat_addr),
        .pat_rdata(pat_rdata), .mul_mode(mul_mode), .mul_in1(mul_in1),
        .mul_in2(mul_in2), .mul_result(mul_result), .mul_error(mul_error),
        .busy(busy), .done(done), .pass(pass), .error_cnt(error_cnt),
        .fail_valid(fail_valid), .fail_idx(fail_idx), .dut_err_seen(dut_err_seen)
    );

    mul_bist_ctrl #(.PATTERN_NUM(NS), .ADDR_W(9), .DATA_W(16), .PAT_W(49)) dut_sat (
        .clk(clk), .rst_n(rst_n), .start(start_s), .pat_addr(pat_addr_s),
        .pat_rdata(pat_rdata_s), .mul_mode(mul_mode_s), .mul_in1(mul_in1_s),
        .mul_in2(mul_in2_s), .mul_result(mul_result_s), .mul_error(1'b0),
        .busy(busy_s), .done(done_s), .pass(pass_s), .error_cnt(error_cnt_s),
        .fail_valid(fail_valid_s), .fail_idx(fail_idx_s), .dut_err_seen(dut_err_seen_s)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_pat_addr"},   32'(pat_addr), 0);
        check({tag, "_mul_in1"},    32'(mul_in1), 0);
        check({tag, "_mul_in2"},    32'(mul_in2), 0);
        check({tag, "_mul_mode"},   32'(mul_mode), 0);
        check({tag, "_busy"},       32'(busy), 0);
        check({tag, "_done"},       32'(done), 0);
        check({tag, "_pass"},       32'(pass), 0);
        check({tag, "_error_cnt"},  32'(error_cnt), 0);
        check({tag, "_fail_valid"}, 32'(fail_valid), 0);
        check({tag, "_fail_idx"},   32'(fail_idx), 0);
        check({tag, "_dut_err"},    32'(dut_err_seen), 0);
    endtask

    // Build the main pattern memory from the table, corrupting marked entries.
    task automatic load_mem();
        logic [15:0] e;
        for (int i = 0; i < N; i++) begin
            e = fp_model(in1_t[i], in2_t[i], mode_t[i]) ^ (corrupt[i] ? 16'h0001 : 16'h0000);
            mem[i] = {in1_t[i], in2_t[i], e, mode_t[i]};
        end
    endtask

    // One full run on the main instance; extra_start > 0 re-pulses start mid-run.
    task automatic run_main(input string name, input int extra_start);
        op_t  o;
        res_t r;
        int   idx;
        r = '0;
        for (int i = 0; i < N; i++) begin
            op_q.push_back('{in1: in1_t[i], in2: in2_t[i], mode: mode_t[i]});
            if (corrupt[i]) begin
                if (!r.fvalid) begin
                    r.fvalid = 1'b1;
                    r.fidx   = 4'(i);
                end
                r.cnt = r.cnt + 8'd1;
            end
        end
        r.pass = (r.cnt == 8'd0);
        r.derr = err_force;
        res_q.push_back(r);

        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check({name, "_busy_rise"}, 32'(busy), 1);
        for (int c = 1; c <= 3 * N; c++) begin
            @(posedge clk);
            #1;
            start = (c == extra_start);
            if (c % 3 == 2) begin
                idx = (c - 2) / 3;
                o = op_q.pop_front();
                check({name, "_pat_addr"}, 32'(pat_addr), 32'(idx));
                check({name, "_in1"}, 32'(mul_in1), 32'(o.in1));
                check({name, "_in2"}, 32'(mul_in2), 32'(o.in2));
                check({name, "_mode"}, 32'(mul_mode), 32'(o.mode));
            end
            if (c < 3 * N) begin
                check({name, "_busy"}, 32'(busy), 1);
                check({name, "_done_early"}, 32'(done), 0);
            end else begin
                check({name, "_busy_fall"}, 32'(busy), 0);
                check({name, "_done"}, 32'(done), 1);
            end
        end
        start = 1'b0;
        r = res_q.pop_front();
        check({name, "_error_cnt"},  32'(error_cnt), 32'(r.cnt));
        check({name, "_fail_valid"}, 32'(fail_valid), 32'(r.fvalid));
        check({name, "_fail_idx"},   32'(fail_idx), 32'(r.fidx));
        check({name, "_pass"},       32'(pass), 32'(r.pass));
        check({name, "_dut_err"},    32'(dut_err_seen), 32'(r.derr));
        $display("run %s: error_cnt=%0d fail_valid=%0d fail_idx=%0d pass=%0d dut_err_seen=%0d",
                 name, error_cnt, fail_valid, fail_idx, pass, dut_err_seen);
    endtask

    initial begin
        int c;
        for (int i = 0; i < N; i++) corrupt[i] = 1'b0;
        load_mem();
        for (int i = 0; i < NS; i++)
            mem_s[i] = {16'(i), 16'h0003, fp_model(16'(i), 16'h0003, 1'b0) ^ 16'h0001, 1'b0};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("rst");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_reset_outputs("post_rst");
        $display("reset: outputs at reset values");

        // All-pass run, then a rerun from DONE
        run_main("all_pass", 0);
        run_main("rerun", 0);

        // Mismatches at indices 3 and 7, then the same with a start pulse in cycle 5
        corrupt[3] = 1'b1;
        corrupt[7] = 1'b1;
        load_mem();
        run_main("inject", 0);
        run_main("start_busy", 5);
        run_main("start_busy_rerun", 0);

        // Multiplier error flag on index 2 with correct products
        corrupt[3] = 1'b0;
        corrupt[7] = 1'b0;
        load_mem();
        err_force = 1'b1;
        run_main("dut_err", 0);
        err_force = 1'b0;

        // Reset during CHECK of index 4
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (14) begin
            @(posedge clk);
            #1;
        end
        check("midrun_pat_addr_before", 32'(pat_addr), 4);
        check("midrun_busy_before", 32'(busy), 1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrun_rst");
        @(negedge clk);
        rst_n = 1'b1;
        $display("reset mid-run: outputs returned to reset values");
        run_main("after_rst", 0);

        // Saturation on the 300-pattern instance, every pattern corrupted
        @(negedge clk);
        start_s = 1'b1;
        @(posedge clk);
        #1;
        start_s = 1'b0;
        c = 0;
        while (!done_s && c < 1000) begin
            @(posedge clk);
            #1;
            c++;
        end
        check("sat_done", 32'(done_s), 1);
        check("sat_cycles", 32'(c), 3 * NS);
        check("sat_error_cnt", 32'(error_cnt_s), 255);
        check("sat_fail_valid", 32'(fail_valid_s), 1);
        check("sat_fail_idx", 32'(fail_idx_s), 0);
        check("sat_pass", 32'(pass_s), 0);
        $display("run saturation: error_cnt=%0d fail_idx=%0d cycles=%0d", error_cnt_s, fail_idx_s, c);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mul_bist_ctrl.md
# mul_bist_ctrl

Hardware initiator for the `fp_mul` datapath. It walks a golden-pattern memory and drives each pattern's operands and mode into a combinational `fp_mul` instance. It compares the product against the expected value and reports a saturating mismatch count, the first failing index, and a done/pass status. It sits beside the systolic array as an on-chip self-test for the PE multiplier, replacing the simulation-only stimulus loop.

## Interface
Parameters:
- `PATTERN_NUM`, 10: number of patterns; must be at least 1.
- `ADDR_W`, 4: pattern address width; must satisfy 2^ADDR_W ≥ PATTERN_NUM.
- `DATA_W`, 16: operand and result width.
- `PAT_W`, 49: pattern word width, equal to 3*DATA_W+1.

Ports:
- `clk`  in  1  single clock; all logic is rising-edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  run request; sampled only in IDLE or DONE.
- `pat_addr`  out  ADDR_W  pattern memory address.
- `pat_rdata`  in  PAT_W  pattern word, valid one cycle after `pat_addr`. Fields: [48:33] input1, [32:17] input2, [16:1] expected, [0] mode.
- `mul_mode`  out  1  mode bit to `fp_mul`.
- `mul_in1`  out  DATA_W  first operand to `fp_mul`.
- `mul_in2`  out  DATA_W  second operand to `fp_mul`.
- `mul_result`  in  DATA_W  combinational product from `fp_mul`.
- `mul_error`  in  1  `fp_mul` error flag.
- `busy`  out  1  high while a run is in progress.
- `done`  out  1  high in DONE.
- `pass`  out  1  high in DONE when `error_cnt`==0.
- `error_cnt`  out  8  mismatch count; saturates at 255.
- `fail_valid`  out  1  at least one mismatch has occurred this run.
- `fail_idx`  out  ADDR_W  index of the first mismatch.
- `dut_err_seen`  out  1  sticky: `mul_error` was high during some CHECK this run.

## Operation
- States: IDLE, FETCH, APPLY, CHECK, DONE.
- IDLE: when `start`=1, clear `error_cnt`, `fail_valid`, `fail_idx`, `dut_err_seen` and `pat_addr`, then go to FETCH.
- FETCH: `pat_addr` holds the current index; go to APPLY.
- APPLY: register the `pat_rdata` fields into `mul_in1`, `mul_in2`, `mul_mode` and an internal `exp_q`; go to CHECK.
- CHECK: compare `mul_result` with `exp_q`.
  - On mismatch: increment `error_cnt`, saturating at 255.
  - On the first mismatch only: set `fail_valid` and load `fail_idx` with `pat_addr`.
  - Set `dut_err_seen` if `mul_error`=1.
  - If `pat_addr`==PATTERN_NUM-1, go to DONE; otherwise increment `pat_addr` and go to FETCH.
- DONE: hold all results. `start`=1 restarts the run exactly as from IDLE.
- `start` in FETCH, APPLY or CHECK is ignored; there is no abort.
- Only `mul_result` is compared. `mul_error` never affects `error_cnt` or `pass`.
- Reset mid-run returns immediately to IDLE with every output at its reset value. The next `start` begins again at index 0.

## Timing
- Reset values: state=IDLE, `pat_addr`=0, `mul_in1`=0, `mul_in2`=0, `mul_mode`=0, `busy`=0, `done`=0, `pass`=0, `error_cnt`=0, `fail_valid`=0, `fail_idx`=0, `dut_err_seen`=0.
- Each pattern takes exactly 3 cycles: FETCH, APPLY, CHECK.
- `busy` goes high on the edge that samples `start`. It stays high for 3*PATTERN_NUM cycles.
- `done` goes high on the edge that leaves the last CHECK. `busy` falls on the same edge.
- `error_cnt`, `fail_*` and `dut_err_seen` update on the edge that leaves CHECK.
- Operands are stable through the whole CHECK cycle, so `fp_mul` has one full cycle of combinational settle time.
- All outputs are registered; `busy`, `done` and `pass` decode from registered state.

## Structure
- `mul_bist_pkg` holds:
  - the state enum;
  - field-position constants IN1_MSB=48, IN1_LSB=33, IN2_MSB=32, IN2_LSB=17, EXP_MSB=16, EXP_LSB=1, MODE_BIT=0;
  - ERR_CNT_W=8.
- One natural sub-module, `sat_counter`, parameterized by width, with `clr` and `inc` inputs. The top-level FSM, field slicing and compare stay in `mul_bist_ctrl`.
- The pattern memory and `fp_mul` are instantiated outside this block.

## Test plan
- **All-pass run:** 10 patterns, including in1=0x3C00, in2=0x4000, exp=0x4000, mode=1, with a bench `fp_mul` model. Pulse `start` → `busy` high for 30 cycles, then `done`=1, `pass`=1, `error_cnt`=0, `fail_valid`=0.
- **Injected mismatches:** corrupt `expected` at indices 3 and 7 → `error_cnt`=2, `fail_valid`=1, `fail_idx`=3, `pass`=0.
- **Saturation:** PATTERN_NUM=300, ADDR_W=9, every pattern corrupted → `error_cnt` stops at 255, `fail_idx`=0.
- **Start while busy:** pulse `start` again in cycle 5 → ignored; `done` still rises 30 cycles after the first `start`. A `start` in DONE clears the results and reruns with identical results.
- **Reset mid-run:** assert `rst_n`=0 during CHECK of index 4 → all outputs return to their reset values at once. The next `start` begins at `pat_addr`=0.
- **DUT error flag:** force `mul_error`=1 on index 2 with a correct result → `dut_err_seen`=1, `error_cnt`=0, `pass`=1.
